keycode_bank: RTL and testbench

Avalon-MM slave for the keyboard path of the SoC. It holds `NUM_KEYS` independent keycode registers written by the Nios II, rather than a single keycode byte, and drives them in parallel to game logic. It also provides a software-to-hardware key-event FIFO with a valid/ready handshake, plus status and control registers. It sits between the HPS/Nios USB-keyboard driver and the game FSM / sprite controllers.

---
 rtl/keycode_bank.sv | 150 +++++++++++++++
 tb/tb_keycode_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/keycode_bank.sv
// Avalon-MM keycode bank: NUM_KEYS parallel keycode registers plus a
// software-to-hardware key-event FIFO, with status and control registers.
module keycode_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_KEYS   = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           chipselect,
  input  logic                           write_n,
  input  logic [31:0]                    writedata,
  output logic [31:0]                    readdata,
  output logic [NUM_KEYS*DATA_WIDTH-1:0] out_keys,
  output logic                           key_active,
  output logic [DATA_WIDTH-1:0]          evt_data,
  output logic                           evt_valid,
  input  logic                           evt_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] A_EVENT  = ADDR_WIDTH'(NUM_KEYS);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(NUM_KEYS + 1);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(NUM_KEYS + 2);

  logic [DATA_WIDTH-1:0] keys_q [NUM_KEYS];
  logic [DATA_WIDTH-1:0] keys_d [NUM_KEYS];
  logic [DATA_WIDTH-1:0] mem_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic bus_wr, push_req, status_wr, ctrl_wr, flush, clr_keys;
  logic fifo_empty, fifo_full, do_push, do_pop, ovf_set;

  assign bus_wr     = chipselect && !write_n;
  assign push_req   = bus_wr && (address == A_EVENT);
  assign status_wr  = bus_wr && (address == A_STATUS);
  assign ctrl_wr    = bus_wr && (address == A_CTRL);
  assign flush      = ctrl_wr && writedata[1];
  assign clr_keys   = ctrl_wr && writedata[0];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));

  // Event handshake: a transfer happens on a rising edge where evt_valid and
  // evt_ready are both high; evt_data is held stable until that transfer.
  assign evt_valid  = !fifo_empty;
  assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : '0;
  assign do_pop     = evt_valid && evt_ready;
  // A pop frees a slot in the same edge, so a push into a full FIFO still lands.
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign ovf_set    = push_req && fifo_full && !do_pop;

  always_comb begin
    out_keys = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      out_keys[i*DATA_WIDTH +: DATA_WIDTH] = keys_q[i];
    end
  end

  assign key_active = |out_keys;

  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      keys_d[i] = keys_q[i];
      if (clr_keys) begin
        keys_d[i] = '0;
      end else if (bus_wr && (address == ADDR_WIDTH'(i))) begin
        keys_d[i] = writedata[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = writedata[DATA_WIDTH-1:0];
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (status_wr && writedata[2]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (address == ADDR_WIDTH'(i)) begin
        readdata = 32'(keys_q[i]);
      end
    end
    if (address == A_STATUS) begin
      readdata = {16'b0, 8'(count_q), 5'b0, ovf_q, fifo_full, fifo_empty};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        keys_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        keys_q[i] <= keys_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_keycode_bank.sv
// Directed self-checking bench for keycode_bank with default parameters
// (KEY 0..5, EVENT 6, STATUS 7, CTRL 8).
module tb_keycode_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [47:0] out_keys;
  logic        key_active;
  logic [7:0]  evt_data;
  logic        evt_valid;
  logic        evt_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  keycode_bank dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_keys(out_keys), .key_active(key_active), .evt_data(evt_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, 64'(readdata), 64'(exp));
  endtask

  task automatic push_evt(input logic [7:0] v, input bit expect_kept);
    bus_write(4'd6, 32'(v));
    if (expect_kept) exp_q.push_back(v);
  endtask

  task automatic drain(input int n);
    logic [7:0] e;
    evt_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      chk("drain_valid", 64'(evt_valid), 64'd1);
      chk("drain_data", 64'(evt_data), 64'(e));
      @(posedge clk);
      #1;
    end
    evt_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    evt_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    chk("rst_keys", 64'(out_keys), 64'd0);
    chk("rst_active", 64'(key_active), 64'd0);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_data", 64'(evt_data), 64'd0);
    read_chk("rst_status", 4'd7, 32'h1);

    // Key register write, readback, and clear
    bus_write(4'd2, 32'hFFFF_FF1A);
    chk("key2_out", 64'(out_keys[23:16]), 64'h1A);
    chk("key2_active", 64'(key_active), 64'd1);
    read_chk("key2_read", 4'd2, 32'h1A);
    address = 4'd3; writedata = 32'h5C; chipselect = 1'b1; write_n = 1'b0;
    #1;
    chk("rd_during_wr", 64'(readdata), 64'd0);
    @(posedge clk); #1; chipselect = 1'b0; write_n = 1'b1;
    read_chk("key3_read", 4'd3, 32'h5C);
    chk("keys_out", 64'(out_keys), 64'h0000_005C_1A00_00);
    read_chk("unmapped_rd", 4'd12, 32'h0);
    bus_write(4'd8, 32'h1);
    chk("clr_keys", 64'(out_keys), 64'd0);
    chk("clr_active", 64'(key_active), 64'd0);

    // Basic push and in-order pop
    push_evt(8'h04, 1'b1);
    push_evt(8'h16, 1'b1);
    push_evt(8'h07, 1'b1);
    read_chk("st_three", 4'd7, 32'h300);
    read_chk("event_rd", 4'd6, 32'h0);
    chk("head_04", 64'(evt_data), 64'h04);
    drain(3);
    chk("empty_valid", 64'(evt_valid), 64'd0);
    read_chk("st_empty", 4'd7, 32'h1);

    // Fill to full, overflow on the ninth push
    for (int i = 0; i < 8; i++) push_evt(8'(8'h30 + i), 1'b1);
    read_chk("st_full", 4'd7, 32'h802);
    push_evt(8'h99, 1'b0);
    read_chk("st_ovf", 4'd7, 32'h806);
    bus_write(4'd7, 32'h4);
    read_chk("st_ovf_clr", 4'd7, 32'h802);
    drain(8);
    read_chk("st_drained", 4'd7, 32'h1);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) push_evt(8'(8'h40 + i), 1'b1);
    address = 4'd6; writedata = 32'h55; chipselect = 1'b1; write_n = 1'b0;
    evt_ready = 1'b1;
    #1;
    chk("full_pp_head", 64'(evt_data), 64'(exp_q.pop_front()));
    exp_q.push_back(8'h55);
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; evt_ready = 1'b0;
    read_chk("full_pp_st", 4'd7, 32'h802);
    drain(8);

    // Push and ready together while empty
    address = 4'd6; writedata = 32'h66; chipselect = 1'b1; write_n = 1'b0;
    evt_ready = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; evt_ready = 1'b0;
    exp_q.push_back(8'h66);
    read_chk("empty_pp_st", 4'd7, 32'h100);
    drain(1);

    // Flush with concurrent pop, overflow clear
    for (int i = 0; i < 5; i++) push_evt(8'(8'h50 + i), 1'b1);
    evt_ready = 1'b1;
    bus_write(4'd8, 32'h2);
    evt_ready = 1'b0;
    exp_q.delete();
    chk("flush_valid", 64'(evt_valid), 64'd0);
    read_chk("flush_st", 4'd7, 32'h1);

    // Flush leaves a set overflow flag alone
    for (int i = 0; i < 9; i++) push_evt(8'(8'h60 + i), 1'b0);
    bus_write(4'd8, 32'h2);
    read_chk("flush_ovf_st", 4'd7, 32'h5);
    bus_write(4'd7, 32'h4);

    // Reset mid-stream overrides a concurrent write and pop
    push_evt(8'h71, 1'b0);
    push_evt(8'h72, 1'b0);
    push_evt(8'h73, 1'b0);
    bus_write(4'd0, 32'h11);
    bus_write(4'd5, 32'h22);
    chk("pre_rst_keys", 64'(out_keys), 64'h2200_0000_0011);
    address = 4'd1; writedata = 32'h33; chipselect = 1'b1; write_n = 1'b0;
    evt_ready = 1'b1; reset_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; evt_ready = 1'b0; reset_n = 1'b1;
    chk("mid_rst_keys", 64'(out_keys), 64'd0);
    chk("mid_rst_active", 64'(key_active), 64'd0);
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    chk("mid_rst_data", 64'(evt_data), 64'd0);
    read_chk("mid_rst_st", 4'd7, 32'h1);
    push_evt(8'h77, 1'b1);
    read_chk("post_rst_st", 4'd7, 32'h100);
    drain(1);
    chk("post_rst_empty", 64'(evt_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
